// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - MDU_WIDTH : default operand width (also the iteration count)
//   - mdu_op_e  : operation encodings driven on op
//   - mdu_state_e : control FSM states
package mdu_pkg;
  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;
endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bus between ID/EX, the mul/div unit and HILORegisters.
//   start/op/rs/rt      : request from ID/EX
//   busy                : stall indication for control
//   hi_out/lo_out       : result, valid while hi_write/lo_write strobe
//   acc/hi_in/lo_in     : multiply-accumulate inputs (only with MDU_MADD_EN)
// Modports: mst = requester side, slv = the mul/div unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             hi_write;
  logic             lo_write;
`ifdef MDU_MADD_EN
  logic             acc;
  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;

  modport mst (output start, op, rs, rt, acc, hi_in, lo_in,
               input  busy, hi_out, lo_out, hi_write, lo_write);
  modport slv (input  start, op, rs, rt, acc, hi_in, lo_in,
               output busy, hi_out, lo_out, hi_write, lo_write);
`else
  modport mst (output start, op, rs, rt,
               input  busy, hi_out, lo_out, hi_write, lo_write);
  modport slv (input  start, op, rs, rt,
               output busy, hi_out, lo_out, hi_write, lo_write);
`endif
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation of the unsigned-magnitude results.
//   i_prod/i_quot/i_rem         : magnitudes from the iteration datapath
//   i_neg_prod/quot/rem         : negate the corresponding value
//   o_prod/o_quot/o_rem         : signed-corrected results
module mdu_sign_fix #(parameter int WIDTH = 32) (
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic [WIDTH-1:0]   i_quot,
  input  logic [WIDTH-1:0]   i_rem,
  input  logic               i_neg_prod,
  input  logic               i_neg_quot,
  input  logic               i_neg_rem,
  output logic [2*WIDTH-1:0] o_prod,
  output logic [WIDTH-1:0]   o_quot,
  output logic [WIDTH-1:0]   o_rem
);
  assign o_prod = i_neg_prod ? -i_prod : i_prod;
  assign o_quot = i_neg_quot ? -i_quot : i_quot;
  assign o_rem  = i_neg_rem  ? -i_rem  : i_rem;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit, one result bit per cycle, fixed latency.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   mdu (slv)  : request in (start/op/rs/rt), result out (hi_out/lo_out)
//                with one-cycle hi_write/lo_write strobes, busy for stalls
// Optional MDU_MADD_EN: multiplies with acc=1 add the latched {hi_in,lo_in}.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic           Clk,
  input  logic           Rst_n,
  mul_div_unit_if.slv    mdu
);
  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_e         r_state, w_state_nxt;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_sign_a, r_sign_b;
  logic [2*WIDTH-1:0] r_acc;     // mult: {partial, multiplier}; div: {rem, quot}
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_wr;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] r_addend;
`endif

  // FSM
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (mdu.start) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // operand capture: signed ops work on magnitudes
  logic             w_signed;
  logic             w_neg_rs, w_neg_rt;
  logic [WIDTH-1:0] w_abs_rs, w_abs_rt;
  assign w_signed = ~mdu.op[0];
  assign w_neg_rs = w_signed & mdu.rs[WIDTH-1];
  assign w_neg_rt = w_signed & mdu.rt[WIDTH-1];
  assign w_abs_rs = w_neg_rs ? -mdu.rs : mdu.rs;
  assign w_abs_rt = w_neg_rt ? -mdu.rt : mdu.rt;

  // one iteration of shift-add multiply
  logic [WIDTH-1:0] w_madd;
  logic [WIDTH:0]   w_msum;
  assign w_madd = r_acc[0] ? r_a : '0;
  assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_madd};

  // one iteration of restoring divide; borrow means the trial failed
  logic [WIDTH:0] w_dshift, w_ddiff;
  assign w_dshift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_b};

  // sign fix-up; a zero divisor leaves the all-ones quotient untouched
  logic [2*WIDTH-1:0] w_fix_prod, w_prod_res;
  logic [WIDTH-1:0]   w_fix_quot, w_fix_rem;
  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_prod     (r_acc),
    .i_quot     (r_acc[WIDTH-1:0]),
    .i_rem      (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg_prod (r_sign_a ^ r_sign_b),
    .i_neg_quot ((r_sign_a ^ r_sign_b) & (r_b != '0)),
    .i_neg_rem  (r_sign_a),
    .o_prod     (w_fix_prod),
    .o_quot     (w_fix_quot),
    .o_rem      (w_fix_rem)
  );

`ifdef MDU_MADD_EN
  assign w_prod_res = w_fix_prod + r_addend;
`else
  assign w_prod_res = w_fix_prod;
`endif

  // datapath
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_wr     <= 1'b0;
`ifdef MDU_MADD_EN
      r_addend <= '0;
`endif
    end else begin
      r_wr <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: if (mdu.start) begin
          r_is_div <= mdu.op[1];
          r_a      <= w_abs_rs;
          r_b      <= w_abs_rt;
          r_sign_a <= w_neg_rs;
          r_sign_b <= w_neg_rt;
          r_acc    <= {{WIDTH{1'b0}}, (mdu.op[1] ? w_abs_rs : w_abs_rt)};
          r_cnt    <= CW'(WIDTH);
`ifdef MDU_MADD_EN
          r_addend <= (mdu.acc && !mdu.op[1]) ? {mdu.hi_in, mdu.lo_in} : '0;
`endif
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (!r_is_div)
            r_acc <= {w_msum, r_acc[WIDTH-1:1]};
          else if (w_ddiff[WIDTH])
            r_acc <= {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
          else
            r_acc <= {w_ddiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
        S_DONE: begin
          r_hi <= r_is_div ? w_fix_rem  : w_prod_res[2*WIDTH-1:WIDTH];
          r_lo <= r_is_div ? w_fix_quot : w_prod_res[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign mdu.busy     = (r_state != S_IDLE);
  assign mdu.hi_out   = r_hi;
  assign mdu.lo_out   = r_lo;
  assign mdu.hi_write = r_wr;
  assign mdu.lo_write = r_wr;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results, strobe timing, busy,
// start-while-busy, divide corner cases and reset mid-operation.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 Clk = ~Clk;

  mul_div_unit_if #(.WIDTH(32)) mdu_bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .mdu   (mdu_bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Issue one op, watch 36 cycles after the accepting edge, check result
  // and timing. inj>0 pulses a competing start inj cycles into BUSY.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int inj);
    int first, nstr, bbad;
    @(posedge Clk); #1;
    mdu_bus.start = 1'b1; mdu_bus.op = op; mdu_bus.rs = a; mdu_bus.rt = b;
    @(posedge Clk); #1;
    mdu_bus.start = 1'b0;
    first = 0; nstr = 0; bbad = 0;
    if (!mdu_bus.busy) bbad++;
    for (int k = 1; k <= 36; k++) begin
      @(posedge Clk); #1;
      if (mdu_bus.hi_write && mdu_bus.lo_write) begin
        nstr++;
        if (first == 0) first = k;
      end else if (mdu_bus.hi_write || mdu_bus.lo_write) nstr += 100;
      if (k <= 32 && !mdu_bus.busy) bbad++;
      if (k == 33 && mdu_bus.busy) bbad++;
      if (inj > 0 && k == inj) begin
        mdu_bus.start = 1'b1; mdu_bus.op = OP_MULTU;
        mdu_bus.rs = 32'hFFFF_FFFF; mdu_bus.rt = 32'hFFFF_FFFF;
      end
      if (inj > 0 && k == inj + 1) mdu_bus.start = 1'b0;
    end
    check({tag, ".hi"}, {32'h0, mdu_bus.hi_out}, {32'h0, exp_hi});
    check({tag, ".lo"}, {32'h0, mdu_bus.lo_out}, {32'h0, exp_lo});
    check({tag, ".strobe_cycle"}, 64'(first), 64'd33);
    check({tag, ".strobe_count"}, 64'(nstr), 64'd1);
    check({tag, ".busy_window"}, 64'(bbad), 64'd0);
  endtask

  initial begin
    int nstr;
    mdu_bus.start = 1'b0; mdu_bus.op = 2'b00;
    mdu_bus.rs = '0; mdu_bus.rt = '0;
`ifdef MDU_MADD_EN
    mdu_bus.acc = 1'b0; mdu_bus.hi_in = '0; mdu_bus.lo_in = '0;
`endif
    #2;
    check("rst.busy",  {63'h0, mdu_bus.busy}, 64'h0);
    check("rst.hilo",  {mdu_bus.hi_out, mdu_bus.lo_out}, 64'h0);
    check("rst.wr",    {62'h0, mdu_bus.hi_write, mdu_bus.lo_write}, 64'h0);
    @(negedge Clk); Rst_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1 check("idle.busy", {63'h0, mdu_bus.busy}, 64'h0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("mult_nn",   OP_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000A, 0);
    run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu",      OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 0);
    run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("div_z",     OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
    run_op("divu_inj",  OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 5);
    run_op("divu_z",    OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 0);

    repeat (4) @(posedge Clk);
    #1 check("hold.hilo", {mdu_bus.hi_out, mdu_bus.lo_out}, 64'h0000_1234_FFFF_FFFF);

`ifdef MDU_MADD_EN
    mdu_bus.acc = 1'b1; mdu_bus.hi_in = 32'h0; mdu_bus.lo_in = 32'hFFFF_FFFF;
    run_op("maddu", OP_MULTU, 32'd1, 32'd1, 32'h0000_0001, 32'h0000_0000, 0);
    mdu_bus.acc = 1'b0;
    run_op("divu_acc_ign", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 0);
    run_op("divu_z2", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 0);
`endif

    // reset in the middle of an operation
    @(posedge Clk); #1;
    mdu_bus.start = 1'b1; mdu_bus.op = OP_DIVU; mdu_bus.rs = 32'd55; mdu_bus.rt = 32'd5;
    @(posedge Clk); #1 mdu_bus.start = 1'b0;
    repeat (10) @(posedge Clk);
    #1 check("mid.busy_before", {63'h0, mdu_bus.busy}, 64'h1);
    Rst_n = 1'b0;
    #1;
    check("mid.busy",  {63'h0, mdu_bus.busy}, 64'h0);
    check("mid.hilo",  {mdu_bus.hi_out, mdu_bus.lo_out}, 64'h0);
    check("mid.wr",    {62'h0, mdu_bus.hi_write, mdu_bus.lo_write}, 64'h0);
    @(posedge Clk); #1 Rst_n = 1'b1;
    nstr = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (mdu_bus.hi_write || mdu_bus.lo_write || mdu_bus.busy) nstr++;
    end
    check("mid.no_strobe", 64'(nstr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
